// File: rtl/imem_access_ctrl_if.sv
// imem_access_ctrl_if: bundles the CPU fetch, host loader and SRAM-side signals of imem_access_ctrl.
// master drives requests and returns SRAM read data; slave is the controller.
interface imem_access_ctrl_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 8
);
  logic                cpu_req;
  logic [ADDR_W-2:0]   cpu_pc;
  logic                cpu_ack;
  logic [2*DATA_W-1:0] cpu_instr;
  logic                host_req;
  logic                host_we;
  logic [ADDR_W-1:0]   host_addr;
  logic [DATA_W-1:0]   host_wdata;
  logic                host_ack;
  logic [DATA_W-1:0]   host_rdata;
  logic [ADDR_W-1:0]   mem_addr;
  logic                mem_we;
  logic [DATA_W-1:0]   mem_din;
  logic [DATA_W-1:0]   mem_dout;
  logic                busy;
  modport master (
    output cpu_req, cpu_pc, host_req, host_we, host_addr, host_wdata, mem_dout,
    input  cpu_ack, cpu_instr, host_ack, host_rdata, mem_addr, mem_we, mem_din, busy
  );
  modport slave (
    input  cpu_req, cpu_pc, host_req, host_we, host_addr, host_wdata, mem_dout,
    output cpu_ack, cpu_instr, host_ack, host_rdata, mem_addr, mem_we, mem_din, busy
  );
endinterface

// File: rtl/imem_access_ctrl.sv
// imem_access_ctrl: arbitrates one instruction-SRAM port between CPU fetches (two bytes -> 16-bit instr) and a host loader.
// Define IMEM_ACCESS_HOST_PRIO_EN to give the host strict priority instead of round-robin.
module imem_access_ctrl #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 8
) (
  input logic clk,
  input logic rst_n,
  imem_access_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, F_HI, F_LO, F_ACK, H_ACC, H_ACK} state_t;
  state_t r_state, w_next;
  logic w_grant_cpu, w_grant_host;
  logic [ADDR_W-2:0] r_pc;
  logic [DATA_W-1:0] r_hi;
  logic [2*DATA_W-1:0] r_instr;
  logic [DATA_W-1:0] r_rdata;
  logic [ADDR_W-1:0] r_mem_addr;
  logic r_mem_we;
  logic [DATA_W-1:0] r_mem_din;
`ifdef IMEM_ACCESS_HOST_PRIO_EN
  assign w_grant_host = bus.host_req;
  assign w_grant_cpu  = bus.cpu_req & ~bus.host_req;
`else
  logic r_last_host;
  // On a conflict the side that did not win last time gets the port.
  assign w_grant_cpu  = bus.cpu_req & (~bus.host_req | r_last_host);
  assign w_grant_host = bus.host_req & (~bus.cpu_req | ~r_last_host);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_last_host <= 1'b1;
    else if (r_state == IDLE && (w_grant_cpu || w_grant_host)) r_last_host <= w_grant_host;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:  w_next = w_grant_cpu ? F_HI : w_grant_host ? H_ACC : IDLE;
      F_HI:  w_next = F_LO;
      F_LO:  w_next = F_ACK;
      H_ACC: w_next = H_ACK;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_pc       <= '0;
      r_hi       <= '0;
      r_instr    <= '0;
      r_rdata    <= '0;
      r_mem_addr <= '0;
      r_mem_we   <= 1'b0;
      r_mem_din  <= '0;
    end else begin
      unique case (r_state)
        IDLE:
          if (w_grant_cpu) begin
            r_pc       <= bus.cpu_pc;
            r_mem_addr <= {bus.cpu_pc, 1'b0};
            r_mem_we   <= 1'b0;
          end else if (w_grant_host) begin
            r_mem_addr <= bus.host_addr;
            r_mem_we   <= bus.host_we;
            r_mem_din  <= bus.host_wdata;
          end
        F_HI: begin
          r_hi       <= bus.mem_dout;
          r_mem_addr <= {r_pc, 1'b1};
        end
        F_LO: r_instr <= {r_hi, bus.mem_dout};
        H_ACC: begin
          if (!r_mem_we) r_rdata <= bus.mem_dout;
          r_mem_we <= 1'b0;
        end
        default: ;
      endcase
    end
  assign bus.cpu_ack    = r_state == F_ACK;
  assign bus.host_ack   = r_state == H_ACK;
  assign bus.busy       = r_state != IDLE;
  assign bus.cpu_instr  = r_instr;
  assign bus.host_rdata = r_rdata;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_we     = r_mem_we;
  assign bus.mem_din    = r_mem_din;
endmodule

// File: tb/tb_imem_access_ctrl.sv
// tb_imem_access_ctrl: directed checks of imem_access_ctrl against a behavioural 8x512 SRAM.
// Expected grant order follows IMEM_ACCESS_HOST_PRIO_EN when defined.
module tb_imem_access_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  imem_access_ctrl_if #(.ADDR_W(9), .DATA_W(8)) bus ();
  imem_access_ctrl #(.ADDR_W(9), .DATA_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  logic [7:0] sram [512];
  always @(posedge clk) if (bus.mem_we) sram[bus.mem_addr] <= bus.mem_din;
  assign bus.mem_dout = sram[bus.mem_addr];
  int checks = 0;
  int failures = 0;
  int we_cycles = 0;
  always @(negedge clk) if (bus.mem_we === 1'b1) we_cycles++;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic host_op(input logic we, input logic [8:0] a, input logic [7:0] d, output int lat);
    @(negedge clk);
    bus.host_req = 1'b1; bus.host_we = we; bus.host_addr = a; bus.host_wdata = d;
    lat = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      lat++;
      if (bus.host_ack) break;
    end
    bus.host_req = 1'b0;
  endtask
  task automatic cpu_fetch(input logic [7:0] pc, output int lat);
    @(negedge clk);
    bus.cpu_req = 1'b1; bus.cpu_pc = pc;
    lat = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      lat++;
      if (bus.cpu_ack) break;
    end
    bus.cpu_req = 1'b0;
  endtask
  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cpu_ack"}, 32'(bus.cpu_ack), 0);
    chk({tag, "_cpu_instr"}, 32'(bus.cpu_instr), 0);
    chk({tag, "_host_ack"}, 32'(bus.host_ack), 0);
    chk({tag, "_host_rdata"}, 32'(bus.host_rdata), 0);
    chk({tag, "_mem_addr"}, 32'(bus.mem_addr), 0);
    chk({tag, "_mem_we"}, 32'(bus.mem_we), 0);
    chk({tag, "_mem_din"}, 32'(bus.mem_din), 0);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
  endtask
  initial begin
    int lat, w0, acks, n;
    logic [5:0] seq;
    bus.cpu_req = 0; bus.cpu_pc = 0;
    bus.host_req = 0; bus.host_we = 0; bus.host_addr = 0; bus.host_wdata = 0;
    repeat (2) @(negedge clk);
    chk_reset_outputs("rst");
    rst_n = 1'b1;
    host_op(1'b1, 9'h000, 8'hA5, lat);
    chk("host_wr_lat", 32'(lat), 2);
    host_op(1'b1, 9'h001, 8'h3C, lat);
    cpu_fetch(8'd0, lat);
    chk("fetch0_lat", 32'(lat), 3);
    chk("fetch0_instr", 32'(bus.cpu_instr), 32'hA53C);
    chk("busy_in_ack", 32'(bus.busy), 1);
    @(negedge clk);
    chk("busy_idle", 32'(bus.busy), 0);
    w0 = we_cycles;
    host_op(1'b1, 9'h1FF, 8'h7E, lat);
    host_op(1'b0, 9'h1FF, 8'h00, lat);
    chk("host_rd_lat", 32'(lat), 2);
    chk("host_rd_1ff", 32'(bus.host_rdata), 32'h7E);
    chk("we_cycles", 32'(we_cycles - w0), 1);
    chk("we_low_ack", 32'(bus.mem_we), 0);
    host_op(1'b1, 9'd510, 8'h12, lat);
    host_op(1'b1, 9'd511, 8'h34, lat);
    chk("rdata_held_on_wr", 32'(bus.host_rdata), 32'h7E);
    cpu_fetch(8'd255, lat);
    chk("fetch255_instr", 32'(bus.cpu_instr), 32'h1234);
    cpu_fetch(8'd0, lat);
    chk("refetch0_instr", 32'(bus.cpu_instr), 32'hA53C);
    // pc moves to 0 once the fetch of 255 is under way
    @(negedge clk);
    bus.cpu_req = 1'b1; bus.cpu_pc = 8'd255;
    @(negedge clk);
    bus.cpu_pc = 8'd0;
    lat = 1;
    for (int i = 0; i < 12; i++) begin
      if (bus.cpu_ack) break;
      @(negedge clk);
      lat++;
    end
    bus.cpu_req = 1'b0;
    chk("pc_change_lat", 32'(lat), 3);
    chk("pc_change_instr", 32'(bus.cpu_instr), 32'h1234);
    @(negedge clk);
    bus.cpu_req = 1'b1; bus.cpu_pc = 8'd0;
    repeat (2) @(negedge clk);
    chk("busy_f_lo", 32'(bus.busy), 1);
    rst_n = 1'b0;
    bus.cpu_req = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    acks = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.cpu_ack) acks++;
    end
    chk("midrst_no_ack", 32'(acks), 0);
    cpu_fetch(8'd255, lat);
    chk("post_rst_lat", 32'(lat), 3);
    chk("post_rst_instr", 32'(bus.cpu_instr), 32'h1234);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus.cpu_req = 1'b1; bus.cpu_pc = 8'd0;
    bus.host_req = 1'b1; bus.host_we = 1'b0; bus.host_addr = 9'h001;
    seq = '0; n = 0;
    for (int i = 0; i < 40 && n < 3; i++) begin
      @(negedge clk);
      if (bus.cpu_ack) begin seq = {seq[3:0], 2'b01}; n++; end
      if (bus.host_ack) begin seq = {seq[3:0], 2'b10}; n++; end
    end
    bus.cpu_req = 1'b0; bus.host_req = 1'b0;
`ifdef IMEM_ACCESS_HOST_PRIO_EN
    chk("grant_order", 32'(seq), 32'b101010);
`else
    chk("grant_order", 32'(seq), 32'b011001);
    chk("rr_cpu_instr", 32'(bus.cpu_instr), 32'hA53C);
`endif
    chk("rr_host_rdata", 32'(bus.host_rdata), 32'h3C);
    repeat (3) @(negedge clk);
    chk("final_idle", 32'(bus.busy), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/imem_access_ctrl.md
Name: imem_access_ctrl

Overview:
Sequencer and arbiter in front of the 8-bit x 512 instruction SRAM (combinational read, write on posedge when write-enable is high). Shares the single SRAM port between the CPU fetch path and a host/testbench loader port. Assembles 16-bit instructions from two consecutive bytes for the CPU. Replaces direct testbench pokes into the RAM array.

Parameters:
ADDR_W, 9, SRAM byte-address width; CPU instruction index width is ADDR_W-1
DATA_W, 8, SRAM word width; cpu_instr width is 2*DATA_W

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
cpu_req  in  1  fetch request, level; held until cpu_ack
cpu_pc  in  ADDR_W-1  instruction index (byte addr = {cpu_pc,0})
cpu_ack  out  1  one-cycle pulse; cpu_instr valid in that cycle
cpu_instr  out  2*DATA_W  fetched instruction, held until next fetch completes
host_req  in  1  host access request, level; held until host_ack
host_we  in  1  1 = write, 0 = read (sampled with host_req)
host_addr  in  ADDR_W  host byte address
host_wdata  in  DATA_W  host write data
host_ack  out  1  one-cycle pulse; host_rdata valid in that cycle for reads
host_rdata  out  DATA_W  host read data, held until next host read
mem_addr  out  ADDR_W  to SRAM addr (registered)
mem_we  out  1  to SRAM write enable (registered)
mem_din  out  DATA_W  to SRAM write data (registered)
mem_dout  in  DATA_W  from SRAM read data (combinational from mem_addr)
busy  out  1  high in every state except IDLE

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset: state=IDLE. cpu_ack=0, cpu_instr=0, host_ack=0, host_rdata=0, mem_addr=0, mem_we=0, mem_din=0, busy=0, last_grant=HOST.
- States: IDLE, F_HI, F_LO, F_ACK, H_ACC, H_ACK.
- IDLE: arbitrate on the sampled requests.
  - Only cpu_req: grant CPU, go to F_HI. Load mem_addr={cpu_pc,1'b0}, mem_we=0.
  - Only host_req: grant HOST, go to H_ACC. Load mem_addr=host_addr, mem_we=host_we, mem_din=host_wdata.
  - Both: round-robin, granting the requester not in last_grant. The first conflict after reset goes to CPU.
  - Update last_grant on every grant.
- F_HI: capture mem_dout into cpu_instr[15:8] staging. Load mem_addr={cpu_pc_latched,1'b1}. Go to F_LO.
- F_LO: capture mem_dout into low byte. Update cpu_instr with {hi,lo}. Go to F_ACK.
- F_ACK: cpu_ack=1 for exactly this cycle, then go to IDLE.
- Fetch latency: req sampled at edge k; ack high in cycle k+3. Back-to-back fetches run at 4 cycles each.
- cpu_pc is latched at the grant edge. Changes to cpu_pc during F_HI/F_LO are ignored.
- H_ACC: mem_we is high for exactly this one cycle, and the SRAM writes at its closing edge. For a read, capture mem_dout into host_rdata at that edge; a write leaves host_rdata unchanged. mem_we returns to 0. Go to H_ACK.
- H_ACK: host_ack=1 for one cycle, then go to IDLE. Host latency: 2 cycles from grant.
- mem_we is never high outside H_ACC. mem_addr and mem_din hold their last value when idle.
- A request still high in an ACK cycle is treated as a new request at the next IDLE evaluation. Requesters must drop req in the ack cycle to avoid a repeat.
- Address wrap: byte address is formed by concatenation, so cpu_pc=255 gives bytes 510/511 with no wrap. host_addr covers the full 0..511 range.
- Reset mid-operation: returns to IDLE immediately and no ack is issued. A write already clocked in H_ACC stays in the SRAM. mem_we drops asynchronously.

Optional Feature:
- Macro IMEM_ACCESS_HOST_PRIO_EN.
- Defined: host has strict priority over CPU in IDLE, and last_grant is unused. This is used for program loading while the CPU is stalled.
- Undefined: round-robin as described above.

Test Plan:
- Host writes 0xA5 to addr 0x000 and 0x3C to 0x001, then CPU fetches cpu_pc=0 -> cpu_ack 3 cycles after grant, cpu_instr=0xA53C.
- Host write 0x7E to 0x1FF, then host read of 0x1FF -> host_ack 2 cycles after grant, host_rdata=0x7E; mem_we high exactly 1 cycle total.
- cpu_req and host_req asserted together from reset, both held through three requests -> grant order CPU, HOST, CPU (HOST, HOST, HOST with IMEM_ACCESS_HOST_PRIO_EN).
- cpu_pc=255 with bytes 510=0x12, 511=0x34 -> cpu_instr=0x1234; cpu_pc changed to 0 during F_HI -> result still 0x1234.
- rst_n pulsed low during F_LO -> cpu_ack never asserts, all outputs return to reset values, busy=0; a new fetch afterwards completes normally.
